// File: rtl/aes_pkg.sv
// Shared encodings for the UART-to-word message packer:
// key-length codes, frame byte counts and FSM state names.
package aes_pkg;

    typedef enum logic [1:0] {
        KEY_128 = 2'd0,
        KEY_192 = 2'd1,
        KEY_256 = 2'd2
    } key_len_e;

    localparam int PT_BYTES      = 16;
    localparam int KEY_BYTES_128 = 16;
    localparam int KEY_BYTES_192 = 24;
    localparam int KEY_BYTES_256 = 32;
    localparam int BUF_BYTES     = PT_BYTES + KEY_BYTES_256;
    localparam int BUF_BITS      = BUF_BYTES * 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_SEND  = 2'd2,
        ST_FLUSH = 2'd3
    } mp_state_e;

    // Code 3 is reserved and falls back to a 128-bit key.
    function automatic logic [1:0] norm_key_len(input logic [1:0] kl);
        return (kl == 2'd3) ? 2'(KEY_128) : kl;
    endfunction

    function automatic logic [5:0] frame_bytes(input logic [1:0] kl);
        logic [5:0] n;
        case (kl)
            KEY_192: n = 6'(PT_BYTES + KEY_BYTES_192);
            KEY_256: n = 6'(PT_BYTES + KEY_BYTES_256);
            default: n = 6'(PT_BYTES + KEY_BYTES_128);
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mp_pack_if.sv
// Packed-word output stream of the message packer.
// master = packer side, slave = consumer side.
interface mp_pack_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] MP_data_out;
    logic                  MP_valid_out;
    logic                  MP_ready_in;
    logic                  MP_key_out;
    logic                  MP_last_out;
    logic [1:0]            key_len_out;

    modport master (
        output MP_data_out,
        output MP_valid_out,
        output MP_key_out,
        output MP_last_out,
        output key_len_out,
        input  MP_ready_in
    );

    modport slave (
        input  MP_data_out,
        input  MP_valid_out,
        input  MP_key_out,
        input  MP_last_out,
        input  key_len_out,
        output MP_ready_in
    );
endinterface

// File: rtl/mp_gap_timer.sv
// Idle-cycle watchdog between bytes of one frame.
// expired is high during the TIMEOUT_CYC-th consecutive idle cycle.
module mp_gap_timer #(
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic clear,
    output logic expired
);
    localparam int            CW   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != LAST)) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = enable && (count_q == LAST);

endmodule

// File: rtl/mp_pack.sv
// Collects a UART frame (16 plaintext + 16/24/32 key bytes) into
// a byte buffer and streams it out as big-endian DATA_WIDTH words.
module mp_pack
    import aes_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] uart_byte_in,
    input  logic       RX_DV_in,
    input  logic [1:0] key_len_in,
    output logic       timeout_err_out,
    output logic       overrun_err_out,
    output logic       busy_out,
    mp_pack_if.master  mp
);
    localparam int BPW      = DATA_WIDTH / 8;
    localparam int PT_WORDS = PT_BYTES / BPW;

    mp_state_e state_q;
    mp_state_e state_d;

    logic [BUF_BITS-1:0] buf_q;
    logic [BUF_BITS-1:0] buf_d;
    logic [5:0]          byte_cnt_q;
    logic [5:0]          byte_cnt_d;
    logic [3:0]          word_cnt_q;
    logic [3:0]          word_cnt_d;
    logic [1:0]          kl_q;
    logic [1:0]          kl_d;
    logic                timeout_q;
    logic                timeout_d;
    logic                overrun_q;
    logic                overrun_d;

    logic [5:0] total_bytes;
    logic [3:0] total_words;
    logic       last_byte;
    logic       last_word;
    logic [8:0] wr_msb;
    logic [8:0] rd_msb;
    logic       gap_expired;
    logic       in_recv;

    assign in_recv     = (state_q == ST_RECV);
    assign total_bytes = frame_bytes(kl_q);
    assign total_words = 4'((int'(total_bytes) + BPW - 1) / BPW);
    assign last_byte   = (byte_cnt_q == total_bytes - 6'd1);
    assign last_word   = (word_cnt_q == total_words - 4'd1);

    // Byte 0 sits at the buffer MSBs so words read out big-endian.
    assign wr_msb = 9'(BUF_BITS - 1) - {byte_cnt_q, 3'b000};
    assign rd_msb = 9'(BUF_BITS - 1) - 9'(int'(word_cnt_q) * DATA_WIDTH);

    mp_gap_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_gap_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (in_recv),
        .clear  (RX_DV_in || !in_recv),
        .expired(gap_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (RX_DV_in) begin
                    state_d = ST_RECV;
                end
            end
            ST_RECV: begin
                if (RX_DV_in) begin
                    if (last_byte) begin
                        state_d = ST_SEND;
                    end
                end else if (gap_expired) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (mp.MP_ready_in && last_word) begin
                    state_d = ST_FLUSH;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mp.MP_valid_out = 1'b0;
        mp.MP_data_out  = '0;
        mp.MP_key_out   = 1'b0;
        mp.MP_last_out  = 1'b0;
        if (state_q == ST_SEND) begin
            mp.MP_valid_out = 1'b1;
            mp.MP_data_out  = buf_q[rd_msb -: DATA_WIDTH];
            mp.MP_key_out   = (word_cnt_q >= 4'(PT_WORDS));
            mp.MP_last_out  = last_word;
        end
    end

    assign busy_out        = (state_q != ST_IDLE);
    assign mp.key_len_out  = kl_q;
    assign timeout_err_out = timeout_q;
    assign overrun_err_out = overrun_q;

    // A new frame clears the buffer, which zero-fills a short last key word.
    always_comb begin
        buf_d      = buf_q;
        byte_cnt_d = byte_cnt_q;
        word_cnt_d = word_cnt_q;
        kl_d       = kl_q;
        timeout_d  = 1'b0;
        overrun_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (RX_DV_in) begin
                    buf_d      = {uart_byte_in, {(BUF_BITS - 8){1'b0}}};
                    kl_d       = norm_key_len(key_len_in);
                    byte_cnt_d = 6'd1;
                    word_cnt_d = '0;
                end
            end
            ST_RECV: begin
                if (RX_DV_in) begin
                    buf_d[wr_msb -: 8] = uart_byte_in;
                    byte_cnt_d         = byte_cnt_q + 6'd1;
                end else if (gap_expired) begin
                    buf_d      = '0;
                    byte_cnt_d = '0;
                    timeout_d  = 1'b1;
                end
            end
            ST_SEND: begin
                overrun_d = RX_DV_in;
                if (mp.MP_ready_in && !last_word) begin
                    word_cnt_d = word_cnt_q + 4'd1;
                end
            end
            default: begin
                overrun_d  = RX_DV_in;
                byte_cnt_d = '0;
                word_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q      <= '0;
            byte_cnt_q <= '0;
            word_cnt_q <= '0;
            kl_q       <= '0;
            timeout_q  <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            buf_q      <= buf_d;
            byte_cnt_q <= byte_cnt_d;
            word_cnt_q <= word_cnt_d;
            kl_q       <= kl_d;
            timeout_q  <= timeout_d;
            overrun_q  <= overrun_d;
        end
    end

endmodule

// File: tb/tb_mp_pack.sv
// Scoreboard bench for mp_pack: 32-bit and 128-bit instances,
// directed frames, timeout, overrun and mid-SEND reset.
`timescale 1ns/1ps
module tb_mp_pack;

    typedef struct packed {
        logic [127:0] d;
        logic         k;
        logic         l;
        logic [1:0]   kl;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] rx_byte_v;
    logic [1:0] kl_v;
    logic       dv32, dv128;
    logic       rdy32_m, rdy128_m, tog32, tbit;
    logic       to32, ov32, busy32;
    logic       to128, ov128, busy128;

    exp_t q32[$];
    exp_t q128[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   first_x, last_x, first_y, last_y;
    int   to_cnt32 = 0;
    int   to_cnt128 = 0;

    mp_pack_if #(.DATA_WIDTH(32))  if32 ();
    mp_pack_if #(.DATA_WIDTH(128)) if128 ();

    assign if32.MP_ready_in  = tog32 ? tbit : rdy32_m;
    assign if128.MP_ready_in = rdy128_m;

    mp_pack #(.DATA_WIDTH(32), .TIMEOUT_CYC(50)) dut32 (
        .clk(clk), .rst_n(rst_n),
        .uart_byte_in(rx_byte_v), .RX_DV_in(dv32), .key_len_in(kl_v),
        .timeout_err_out(to32), .overrun_err_out(ov32),
        .busy_out(busy32), .mp(if32)
    );

    mp_pack #(.DATA_WIDTH(128), .TIMEOUT_CYC(50)) dut128 (
        .clk(clk), .rst_n(rst_n),
        .uart_byte_in(rx_byte_v), .RX_DV_in(dv128), .key_len_in(kl_v),
        .timeout_err_out(to128), .overrun_err_out(ov128),
        .busy_out(busy128), .mp(if128)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        tbit = 1'b0;
        forever begin
            @(posedge clk);
            #2 tbit = ~tbit;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Monitor: compare the presented word with the queue head each cycle;
    // pop only when the word is accepted.
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (to32)  to_cnt32++;
            if (to128) to_cnt128++;
            if (if32.MP_valid_out) begin
                if (q32.size() == 0) begin
                    chk("w32_unexpected", 128'(if32.MP_valid_out), 128'd0);
                end else begin
                    chk("w32_data", 128'(if32.MP_data_out), q32[0].d);
                    chk("w32_key",  128'(if32.MP_key_out),  128'(q32[0].k));
                    chk("w32_last", 128'(if32.MP_last_out), 128'(q32[0].l));
                    chk("w32_kl",   128'(if32.key_len_out), 128'(q32[0].kl));
                    if (if32.MP_ready_in) begin
                        void'(q32.pop_front());
                        if (first_x < 0) first_x = cyc;
                        last_x = cyc;
                    end
                end
            end
            if (if128.MP_valid_out) begin
                if (q128.size() == 0) begin
                    chk("w128_unexpected", 128'(if128.MP_valid_out), 128'd0);
                end else begin
                    chk("w128_data", if128.MP_data_out, q128[0].d);
                    chk("w128_key",  128'(if128.MP_key_out),  128'(q128[0].k));
                    chk("w128_last", 128'(if128.MP_last_out), 128'(q128[0].l));
                    chk("w128_kl",   128'(if128.key_len_out), 128'(q128[0].kl));
                    if (if128.MP_ready_in) begin
                        void'(q128.pop_front());
                        if (first_y < 0) first_y = cyc;
                        last_y = cyc;
                    end
                end
            end
        end
    end

    function automatic int nbytes(input logic [1:0] kl);
        case (kl)
            2'd1:    return 40;
            2'd2:    return 48;
            default: return 32;
        endcase
    endfunction

    task automatic push_frame(input bit which, input logic [1:0] kl,
                              input logic [7:0] base);
        int   bpw;
        int   tot;
        int   nw;
        int   idx;
        exp_t e;
        bpw = which ? 16 : 4;
        tot = nbytes(kl);
        nw  = (tot + bpw - 1) / bpw;
        for (int w = 0; w < nw; w++) begin
            e.d = '0;
            for (int j = 0; j < bpw; j++) begin
                idx = w * bpw + j;
                e.d = {e.d[119:0], (idx < tot) ? base + 8'(idx) : 8'h00};
            end
            e.k  = (w * bpw >= 16);
            e.l  = (w == nw - 1);
            e.kl = (kl == 2'd3) ? 2'd0 : kl;
            if (which) q128.push_back(e);
            else       q32.push_back(e);
        end
    endtask

    task automatic rx(input bit which, input logic [7:0] b,
                      input logic [1:0] kl);
        rx_byte_v = b;
        kl_v      = kl;
        if (which) dv128 = 1'b1;
        else       dv32  = 1'b1;
        @(negedge clk);
        dv32  = 1'b0;
        dv128 = 1'b0;
    endtask

    task automatic send_frame(input bit which, input logic [1:0] kl,
                              input logic [7:0] base, input int nb);
        @(negedge clk);
        for (int i = 0; i < nb; i++) rx(which, base + 8'(i), kl);
    endtask

    task automatic set_rdy(input bit which, input logic v);
        @(posedge clk);
        #2;
        if (which) rdy128_m = v;
        else       rdy32_m  = v;
    endtask

    task automatic drain(input bit which, input int budget);
        int n;
        n = 0;
        while (n < budget &&
               (which ? (q128.size() != 0 || busy128)
                      : (q32.size() != 0 || busy32))) begin
            @(negedge clk);
            n++;
        end
        if (which) begin
            chk("drain128_left", 128'(q128.size()), 128'd0);
            chk("drain128_busy", 128'(busy128), 128'd0);
        end else begin
            chk("drain32_left", 128'(q32.size()), 128'd0);
            chk("drain32_busy", 128'(busy32), 128'd0);
        end
    endtask

    initial begin
        int lastb;
        int k;
        bit seen;
        rst_n     = 1'b0;
        rx_byte_v = 8'h00;
        kl_v      = 2'd0;
        dv32      = 1'b0;
        dv128     = 1'b0;
        rdy32_m   = 1'b1;
        rdy128_m  = 1'b1;
        tog32     = 1'b0;
        first_x   = -1;
        last_x    = -1;
        first_y   = -1;
        last_y    = -1;
        #12;
        chk("rst_data",  128'(if32.MP_data_out),  128'd0);
        chk("rst_valid", 128'(if32.MP_valid_out), 128'd0);
        chk("rst_key",   128'(if32.MP_key_out),   128'd0);
        chk("rst_last",  128'(if32.MP_last_out),  128'd0);
        chk("rst_kl",    128'(if32.key_len_out),  128'd0);
        chk("rst_busy",  128'(busy32),            128'd0);
        chk("rst_v128",  128'(if128.MP_valid_out), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 32-bit, 128-bit key, back-to-back words
        push_frame(1'b0, 2'd0, 8'h00);
        send_frame(1'b0, 2'd0, 8'h00, 32);
        lastb = cyc;
        drain(1'b0, 100);
        chk("t1_first_cyc", 128'(first_x), 128'(lastb));
        chk("t1_last_cyc",  128'(last_x),  128'(lastb + 7));

        // 128-bit, 192-bit key: last key word half zero
        q128.push_back('{d: 128'h000102030405060708090a0b0c0d0e0f,
                         k: 1'b0, l: 1'b0, kl: 2'd1});
        q128.push_back('{d: 128'h101112131415161718191a1b1c1d1e1f,
                         k: 1'b1, l: 1'b0, kl: 2'd1});
        q128.push_back('{d: 128'h20212223242526270000000000000000,
                         k: 1'b1, l: 1'b1, kl: 2'd1});
        send_frame(1'b1, 2'd1, 8'h00, 40);
        lastb = cyc;
        drain(1'b1, 100);
        chk("t2_first_cyc", 128'(first_y), 128'(lastb));
        chk("t2_last_cyc",  128'(last_y),  128'(lastb + 2));

        // 32-bit, 256-bit key, ready toggling
        @(posedge clk);
        #2 tog32 = 1'b1;
        push_frame(1'b0, 2'd2, 8'h40);
        send_frame(1'b0, 2'd2, 8'h40, 48);
        drain(1'b0, 200);
        @(posedge clk);
        #2 tog32 = 1'b0;

        // gap timeout after 10 bytes
        send_frame(1'b0, 2'd0, 8'h60, 10);
        k    = 0;
        seen = 1'b0;
        while (!seen && k < 200) begin
            @(posedge clk);
            #1;
            k++;
            if (to32) seen = 1'b1;
        end
        chk("t4_timeout_cyc", 128'(k), 128'd50);
        chk("t4_idle_busy", 128'(busy32), 128'd0);
        @(posedge clk);
        #1;
        chk("t4_pulse_width", 128'(to32), 128'd0);
        push_frame(1'b0, 2'd3, 8'h80);
        send_frame(1'b0, 2'd3, 8'h80, 32);
        drain(1'b0, 100);

        // byte arriving in the expiry cycle wins over timeout
        push_frame(1'b1, 2'd0, 8'hC0);
        @(negedge clk);
        for (int i = 0; i < 5; i++) rx(1'b1, 8'hC0 + 8'(i), 2'd0);
        repeat (49) @(negedge clk);
        for (int i = 5; i < 32; i++) rx(1'b1, 8'hC0 + 8'(i), 2'd0);
        drain(1'b1, 100);
        chk("t5_no_timeout", 128'(to_cnt128), 128'd0);

        // overrun during SEND leaves the stream intact
        set_rdy(1'b0, 1'b0);
        push_frame(1'b0, 2'd0, 8'hA0);
        send_frame(1'b0, 2'd0, 8'hA0, 32);
        chk("t6_in_send", 128'(if32.MP_valid_out), 128'd1);
        rx(1'b0, 8'hFF, 2'd2);
        chk("t6_overrun", 128'(ov32), 128'd1);
        @(negedge clk);
        chk("t6_overrun_width", 128'(ov32), 128'd0);
        set_rdy(1'b0, 1'b1);
        drain(1'b0, 100);

        // reset mid-SEND, then a fresh frame
        set_rdy(1'b0, 1'b0);
        push_frame(1'b0, 2'd2, 8'h20);
        send_frame(1'b0, 2'd2, 8'h20, 48);
        chk("t7_in_send", 128'(if32.MP_valid_out), 128'd1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        q32.delete();
        #1;
        chk("t7_data",  128'(if32.MP_data_out),  128'd0);
        chk("t7_valid", 128'(if32.MP_valid_out), 128'd0);
        chk("t7_key",   128'(if32.MP_key_out),   128'd0);
        chk("t7_last",  128'(if32.MP_last_out),  128'd0);
        chk("t7_kl",    128'(if32.key_len_out),  128'd0);
        chk("t7_busy",  128'(busy32),            128'd0);
        chk("t7_err",   128'({to32, ov32}),      128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        set_rdy(1'b0, 1'b1);
        push_frame(1'b0, 2'd1, 8'h30);
        send_frame(1'b0, 2'd1, 8'h30, 40);
        drain(1'b0, 100);

        chk("timeouts32",  128'(to_cnt32),  128'd1);
        chk("timeouts128", 128'(to_cnt128), 128'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
